mem_stage: RTL

- LC-3b pipeline MEM stage; sits between the EX/MEM pipeline register and write_back.
- Issues data-memory accesses for LDR/STR/LDB/STB/LDI/STI/TRAP.
- Stalls upstream until the memory responds.
- Registers the results into the MEM/WB latch that feeds write_back: mem_address, data, cw, new_pc, alu_out, ir and valid.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_stage_if.sv | 37 +++
 rtl/mem_stage_align.sv | 41 ++++
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
// Shared LC-3b types used by the MEM stage and its data-memory interface.
//   lc3b_word          16-bit datapath word
//   lc3b_mem_wmask     byte enables, [1] = high byte
//   lc3b_control_word  per-instruction control bits carried down the pipeline
// ----------------------------------------------------------------------------
package mem_stage_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef struct packed {
      logic load_regfile;
      logic load_cc;
      logic mem_read;
      logic mem_write;
      logic mem_byte;
      logic mem_indirect;
   } lc3b_control_word;

   localparam lc3b_mem_wmask WMASK_WORD = 2'b11;
   localparam lc3b_mem_wmask WMASK_HI   = 2'b10;
   localparam lc3b_mem_wmask WMASK_LO   = 2'b01;

   // Sign-extend a loaded byte to a full word.
   function automatic lc3b_word sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if
// Data-memory bus between the MEM stage (master) and data memory (slave).
//   dmem_address  access address
//   dmem_read     read request
//   dmem_write    write request
//   dmem_wmask    byte enables for writes, [1] = high byte
//   dmem_wdata    write data
//   dmem_rdata    read data, valid in the dmem_resp cycle
//   dmem_resp     access complete, one-cycle pulse
// Handshake: the master holds dmem_read or dmem_write, together with address,
// mask and write data, stable until the cycle in which the slave raises
// dmem_resp; that cycle completes the access and the master may change or
// drop the request on the following cycle. dmem_resp without a request is
// ignored.
// ----------------------------------------------------------------------------
interface mem_stage_if;
   import mem_stage_pkg::*;

   lc3b_word      dmem_address;
   logic          dmem_read;
   logic          dmem_write;
   lc3b_mem_wmask dmem_wmask;
   lc3b_word      dmem_wdata;
   lc3b_word      dmem_rdata;
   logic          dmem_resp;

   modport master (
      output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
      input  dmem_rdata, dmem_resp
   );

   modport slave (
      input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
      output dmem_rdata, dmem_resp
   );
endinterface

// File: rtl/mem_stage_align.sv
// ----------------------------------------------------------------------------
// mem_align
// Combinational address/lane handling for one data-memory access.
//   addr         unaligned access address
//   byte_access  1 = byte access, 0 = word access
//   store_data   source register value for stores
//   rdata        raw read data from memory
//   address      bus address (bit 0 cleared for word accesses)
//   wmask        byte enables
//   wdata        write data (byte replicated to both lanes for byte stores)
//   load_data    load result after lane select and sign extension
// ----------------------------------------------------------------------------
module mem_align
   import mem_stage_pkg::*;
(
   input  lc3b_word      addr,
   input  logic          byte_access,
   input  lc3b_word      store_data,
   input  lc3b_word      rdata,
   output lc3b_word      address,
   output lc3b_mem_wmask wmask,
   output lc3b_word      wdata,
   output lc3b_word      load_data
);

   always_comb begin
      if (byte_access) begin
         address   = addr;
         wmask     = addr[0] ? WMASK_HI : WMASK_LO;
         // Replicate the byte so the mask alone picks the lane.
         wdata     = {store_data[7:0], store_data[7:0]};
         load_data = sext8(addr[0] ? rdata[15:8] : rdata[7:0]);
      end else begin
         address   = {addr[15:1], 1'b0};
         wmask     = WMASK_WORD;
         wdata     = store_data;
         load_data = rdata;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
// LC-3b MEM pipeline stage. Issues data-memory accesses for loads, stores and
// the two-access indirect forms, stalls upstream until the final access
// completes, then loads the MEM/WB latch.
//   clock, reset      pipeline clock, async active-high reset
//   valid_in          EX/MEM holds a real instruction
//   cw_in, ir_in      control word and instruction
//   alu_out_in        effective address or ALU result
//   store_data_in     SR value for stores
//   new_pc_in         PC+2 / link value
//   mem_stall         hold EX/MEM and all earlier stages
//   dmem              data-memory bus (master side)
//   *_out, valid_out  MEM/WB latch contents
//   state_dbg         current access state (0 idle, 1 access, 2 ind_ptr,
//                     3 ind_access)
// ----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_in,
   input  lc3b_control_word cw_in,
   input  lc3b_word         ir_in,
   input  lc3b_word         alu_out_in,
   input  lc3b_word         store_data_in,
   input  lc3b_word         new_pc_in,
   output logic             mem_stall,
   mem_stage_if.master      dmem,
   output lc3b_word         mem_address_out,
   output lc3b_word         data_out,
   output lc3b_control_word cw_out,
   output lc3b_word         new_pc_out,
   output lc3b_word         alu_out_out,
   output lc3b_word         ir_out,
   output logic             valid_out,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_ACCESS     = 2'd1,
      S_IND_PTR    = 2'd2,
      S_IND_ACCESS = 2'd3
   } state_t;

   state_t   state, state_next;
   lc3b_word ptr_reg;

   logic     need_mem;
   logic     is_read;
   logic     is_write;
   logic     ptr_phase;    // current access is the pointer fetch of LDI/STI
   logic     final_phase;  // current access is the instruction's last one
   logic     final_resp;
   lc3b_word final_addr;
   lc3b_word access_addr;
   lc3b_word load_data;

   // A read takes precedence when both direction bits are set.
   assign need_mem = valid_in & (cw_in.mem_read | cw_in.mem_write);
   assign is_read  = cw_in.mem_read;
   assign is_write = cw_in.mem_write & ~cw_in.mem_read;

   assign state_dbg = state;

   // ---------------- state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (ptr_phase && dmem.dmem_resp) begin
         ptr_reg <= dmem.dmem_rdata;
      end
   end

   // ---------------- next-state logic ----------------
   // Accesses start in S_IDLE in the cycle the instruction arrives, so a
   // response in that first cycle skips the corresponding wait state.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (need_mem) begin
               if (cw_in.mem_indirect) begin
                  state_next = dmem.dmem_resp ? S_IND_ACCESS : S_IND_PTR;
               end else begin
                  state_next = dmem.dmem_resp ? S_IDLE : S_ACCESS;
               end
            end
         end
         S_IND_PTR: begin
            if (!need_mem) begin
               state_next = S_IDLE;
            end else if (dmem.dmem_resp) begin
               state_next = S_IND_ACCESS;
            end
         end
         S_ACCESS, S_IND_ACCESS: begin
            if (!need_mem || dmem.dmem_resp) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      ptr_phase   = 1'b0;
      final_phase = 1'b0;
      final_addr  = alu_out_in;
      case (state)
         S_IDLE: begin
            ptr_phase   = need_mem & cw_in.mem_indirect;
            final_phase = need_mem & ~cw_in.mem_indirect;
         end
         S_IND_PTR: begin
            ptr_phase = need_mem;
         end
         S_ACCESS: begin
            final_phase = need_mem;
         end
         S_IND_ACCESS: begin
            final_phase = need_mem;
            final_addr  = ptr_reg;
         end
         default: begin
            ptr_phase   = 1'b0;
            final_phase = 1'b0;
         end
      endcase
   end

   assign access_addr = ptr_phase ? alu_out_in : final_addr;
   assign final_resp  = final_phase & dmem.dmem_resp;
   assign mem_stall   = need_mem & ~final_resp;

   // Requests drop in the same cycle reset rises; nothing is retried.
   assign dmem.dmem_read  = ~reset & (ptr_phase | (final_phase & is_read));
   assign dmem.dmem_write = ~reset & final_phase & is_write;

   // The pointer fetch is always a word read.
   mem_align u_align (
      .addr        (access_addr),
      .byte_access (cw_in.mem_byte & ~ptr_phase),
      .store_data  (store_data_in),
      .rdata       (dmem.dmem_rdata),
      .address     (dmem.dmem_address),
      .wmask       (dmem.dmem_wmask),
      .wdata       (dmem.dmem_wdata),
      .load_data   (load_data)
   );

   // ---------------- MEM/WB latch ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_address_out <= '0;
         data_out        <= '0;
         cw_out          <= '0;
         new_pc_out      <= '0;
         alu_out_out     <= '0;
         ir_out          <= '0;
         valid_out       <= 1'b0;
      end else if (!mem_stall) begin
         mem_address_out <= need_mem ? final_addr : alu_out_in;
         data_out        <= (need_mem && is_read) ? load_data : '0;
         cw_out          <= valid_in ? cw_in : '0;
         new_pc_out      <= new_pc_in;
         alu_out_out     <= alu_out_in;
         ir_out          <= ir_in;
         valid_out       <= valid_in;
      end
   end

endmodule
